// File: rtl/ili_pio_out.sv
// ili_pio_out: Avalon-MM output port for the TFT control lines.
// Holds a data register with atomic set/clear access and a hardware
// timed-pulse generator that inverts a masked group of pins for exactly
// len+1 clock cycles, so software never has to time a strobe itself.
module ili_pio_out #(
  parameter int              WIDTH         = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b1}},
  parameter int              CNT_W         = 16,
  parameter int              PULSE_DEFAULT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             busy
);

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] ADDR_PINS      = 3'd2;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE     = 3'd6;

  localparam logic [CNT_W-1:0] LEN_RESET = CNT_W'(PULSE_DEFAULT);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] mask;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] cnt;

  logic             wr_en;
  logic             pulse_wr;
  logic [WIDTH-1:0] wr_bits;
  logic [CNT_W-1:0] wr_len;
  logic             unused_wdata;

  // Bus write decode; bits above WIDTH / CNT_W are simply dropped.
  assign wr_en        = chipselect & ~write_n;
  assign pulse_wr     = wr_en && (address == ADDR_PULSE);
  assign wr_bits      = writedata[WIDTH-1:0];
  assign wr_len       = writedata[CNT_W-1:0];
  assign unused_wdata = ^writedata;

  // Data register: plain load, atomic OR-set and AND-NOT-clear, all
  // effective immediately even while a pulse is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:     data <= wr_bits;
        ADDR_OUTSET:   data <= data | wr_bits;
        ADDR_OUTCLEAR: data <= data & ~wr_bits;
        default:       data <= data;
      endcase
    end
  end

  // Pulse length register; a running pulse keeps its own copy in cnt,
  // so rewriting this only affects later pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len <= LEN_RESET;
    end else if (wr_en && (address == ADDR_PULSE_LEN)) begin
      len <= wr_len;
    end
  end

  // Pulse sequencer: load mask/cnt on a PULSE write, count down to zero,
  // then release. The final active edge (cnt==0) is also the first edge
  // at which busy is seen low by the bus, so a PULSE write landing there
  // chains straight into the next pulse with no idle gap; any other
  // PULSE write during a pulse is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mask  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pulse_wr) begin
            state <= ACTIVE;
            mask  <= wr_bits;
            cnt   <= len;
          end
        end
        ACTIVE: begin
          if (cnt == '0) begin
            if (pulse_wr) begin
              mask <= wr_bits;
              cnt  <= len;
            end else begin
              state <= IDLE;
              mask  <= '0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Pin outputs come from registers only: data with the pulse mask
  // inverted on top while the sequencer is active.
  assign busy     = (state == ACTIVE);
  assign out_port = data ^ (busy ? mask : '0);

  // Zero-latency read mux; reads have no side effects.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata[WIDTH-1:0] = data;
      ADDR_PULSE_LEN: readdata[CNT_W-1:0] = len;
      ADDR_PINS:      readdata[WIDTH-1:0] = out_port;
      ADDR_PULSE:     readdata[0]         = busy;
      default:        readdata            = '0;
    endcase
  end

endmodule

// File: tb/tb_ili_pio_out.sv
// tb_ili_pio_out: directed and randomized checks of ili_pio_out against
// a cycle-count reference model (pulse described by its end edge).
module tb_ili_pio_out;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        busy;

  logic [2:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [3:0]  s_out_port;
  logic        s_busy;

  int checks;
  int failures;

  // Reference model: edge counter, registers, and the edge at which the
  // current pulse ends (pulse visible while cyc < m_end).
  longint      cyc;
  longint      m_end;
  logic [7:0]  m_data;
  logic [15:0] m_len;
  logic [7:0]  m_mask;

  ili_pio_out dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .busy(busy)
  );

  ili_pio_out #(.WIDTH(4), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .address(s_address), .chipselect(s_chipselect),
    .write_n(s_write_n), .writedata(s_writedata), .readdata(s_readdata),
    .out_port(s_out_port), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_busy();
    return (cyc < m_end);
  endfunction

  function automatic logic [7:0] model_out();
    return model_busy() ? (m_data ^ m_mask) : m_data;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'b0, m_data};
      3'd1:    return {16'b0, m_len};
      3'd2:    return {24'b0, model_out()};
      3'd6:    return {31'b0, model_busy()};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_data = 8'hFF;
    m_len  = 16'd15;
    m_mask = 8'h00;
    m_end  = 0;
  endtask

  // A write sampled at edge k (cyc == k after the edge).
  task automatic model_write(input logic [2:0] a, input logic [31:0] wd);
    case (a)
      3'd0: m_data = wd[7:0];
      3'd1: m_len  = wd[15:0];
      3'd4: m_data = m_data | wd[7:0];
      3'd5: m_data = m_data & ~wd[7:0];
      3'd6: begin
        if (cyc >= m_end) begin
          m_mask = wd[7:0];
          m_end  = cyc + longint'(m_len) + 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    checkOutput({tag, "_out"}, {24'b0, out_port}, {24'b0, model_out()});
    checkOutput({tag, "_busy"}, {31'b0, busy}, {31'b0, model_busy()});
  endtask

  task automatic check_read(input string tag, input logic [2:0] a,
                            input logic [31:0] exp);
    address = a;
    #1;
    checkOutput(tag, readdata, exp);
  endtask

  // One bus write on the main instance; starts and ends just after a negedge.
  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] wd);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    cyc++;
    model_write(a, wd);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic small_write(input logic [2:0] a, input logic [31:0] wd);
    s_chipselect = 1'b1;
    s_write_n    = 1'b0;
    s_address    = a;
    s_writedata  = wd;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    s_chipselect = 1'b0;
    s_write_n    = 1'b1;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    longint k;
    logic [2:0] ra;
    logic [2:0] wa;
    logic [31:0] wd;
    int r;

    checks = 0; failures = 0; cyc = 0;
    reset = 1'b0;
    address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    s_address = 3'd0; s_chipselect = 1'b0; s_write_n = 1'b1; s_writedata = '0;
    model_reset();

    // Reset
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_out", {24'b0, out_port}, 32'hFF);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_small_out", {28'b0, s_out_port}, 32'hF);
    @(negedge clk);
    repeat (3) idle_cycle();
    reset = 1'b0;
    check_read("rst_len", 3'd1, 32'd15);
    check_read("rst_busyreg", 3'd6, 32'd0);
    checkOutput("rst_rel_out", {24'b0, out_port}, 32'hFF);
    $display("[TB] reset checks done");

    // Set / clear
    applyStimulus(3'd0, 32'h0000_00F0);
    checkOutput("data_wr", {24'b0, out_port}, 32'hF0);
    applyStimulus(3'd4, 32'h0000_0005);
    checkOutput("outset", {24'b0, out_port}, 32'hF5);
    applyStimulus(3'd5, 32'h0000_0030);
    checkOutput("outclear", {24'b0, out_port}, 32'hC5);
    check_read("data_rd", 3'd0, 32'hC5);
    check_read("pins_rd", 3'd2, 32'hC5);

    // Pulse width, len=3 then len=0
    applyStimulus(3'd0, 32'hFF);
    applyStimulus(3'd1, 32'd3);
    applyStimulus(3'd6, 32'h01);
    for (int i = 0; i <= 4; i++) begin
      checkOutput("pw3_out", {24'b0, out_port}, (i < 4) ? 32'hFE : 32'hFF);
      checkOutput("pw3_busy", {31'b0, busy}, (i < 4) ? 32'h1 : 32'h0);
      check_model("pw3_model");
      idle_cycle();
    end
    applyStimulus(3'd1, 32'd0);
    applyStimulus(3'd6, 32'h01);
    checkOutput("pw0_out0", {24'b0, out_port}, 32'hFE);
    checkOutput("pw0_busy0", {31'b0, busy}, 32'h1);
    idle_cycle();
    checkOutput("pw0_out1", {24'b0, out_port}, 32'hFF);
    checkOutput("pw0_busy1", {31'b0, busy}, 32'h0);

    // Back-to-back pulse written exactly at the release edge
    applyStimulus(3'd1, 32'd2);
    applyStimulus(3'd6, 32'h01);
    idle_cycle();
    idle_cycle();
    checkOutput("b2b_busy_a", {31'b0, busy}, 32'h1);
    applyStimulus(3'd6, 32'h04);
    checkOutput("b2b_out", {24'b0, out_port}, 32'hFB);
    checkOutput("b2b_busy_b", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      check_model("b2b_model");
      idle_cycle();
    end
    checkOutput("b2b_end", {24'b0, out_port}, 32'hFF);

    // Overlap: ignored PULSE write and DATA write during a pulse
    applyStimulus(3'd1, 32'd10);
    applyStimulus(3'd6, 32'h01);
    k = cyc;
    idle_cycle();
    idle_cycle();
    applyStimulus(3'd6, 32'h02);
    applyStimulus(3'd0, 32'h0F);
    checkOutput("ovl_out", {24'b0, out_port}, 32'h0E);
    applyStimulus(3'd1, 32'd1);
    while (cyc < k + 10) begin
      check_model("ovl_model");
      idle_cycle();
    end
    checkOutput("ovl_busy_last", {31'b0, busy}, 32'h1);
    checkOutput("ovl_out_last", {24'b0, out_port}, 32'h0E);
    idle_cycle();
    checkOutput("ovl_busy_end", {31'b0, busy}, 32'h0);
    checkOutput("ovl_out_end", {24'b0, out_port}, 32'h0F);

    // Truncation on the narrow instance
    small_write(3'd0, 32'hFFFF_FFA5);
    small_write(3'd1, 32'h0000_0013);
    s_address = 3'd0;
    #1 checkOutput("trunc_data", s_readdata, 32'h5);
    s_address = 3'd1;
    #1 checkOutput("trunc_len", s_readdata, 32'h3);
    checkOutput("trunc_out", {28'b0, s_out_port}, 32'h5);

    // Reset mid-pulse
    applyStimulus(3'd0, 32'hFF);
    applyStimulus(3'd1, 32'd100);
    applyStimulus(3'd6, 32'h80);
    checkOutput("rmp_start", {24'b0, out_port}, 32'h7F);
    repeat (20) idle_cycle();
    checkOutput("rmp_mid", {24'b0, out_port}, 32'h7F);
    reset = 1'b1;
    #1;
    checkOutput("rmp_out", {24'b0, out_port}, 32'hFF);
    checkOutput("rmp_busy", {31'b0, busy}, 32'h0);
    model_reset();
    idle_cycle();
    idle_cycle();
    reset = 1'b0;
    for (int i = 0; i < 110; i++) begin
      check_model("rmp_after");
      idle_cycle();
    end
    checkOutput("rmp_final_busy", {31'b0, busy}, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        idle_cycle();
      end else begin
        wa = (r < 6) ? 3'd6 : 3'($urandom_range(0, 7));
        wd = $urandom;
        if (wa == 3'd1) wd = (wd & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
        applyStimulus(wa, wd);
      end
      check_model("rnd");
      case ($urandom_range(0, 5))
        0: ra = 3'd0;
        1: ra = 3'd1;
        2: ra = 3'd2;
        3: ra = 3'd3;
        4: ra = 3'd6;
        default: ra = 3'd7;
      endcase
      check_read("rnd_rd", ra, model_read(ra));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
